// File: rtl/cpu_types_pkg.sv
// Shared CPU-wide types and widths, plus the instruction-cache FSM encoding.
package cpu_types_pkg;

  localparam int WORD_W     = 32;
  localparam int BYTE_OFF_W = 2;

  typedef enum logic {
    ICACHE_IDLE = 1'b0,
    ICACHE_FILL = 1'b1
  } icache_state_t;

endpackage

// File: rtl/icache_way.sv
// One way of the instruction cache: valid, tag and data per set.
// Asynchronous read port for the lookup, synchronous write port for fills.
module icache_way
  import cpu_types_pkg::*;
#(
  parameter int SETS        = 8,
  parameter int BLOCK_WORDS = 2,
  parameter int TAG_W       = 26,
  parameter int IDX_W       = 3,
  parameter int CNT_W       = 1
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic                flush_all,
  input  logic [IDX_W-1:0]    rd_idx,
  input  logic [CNT_W-1:0]    rd_off,
  output logic                rd_valid,
  output logic [TAG_W-1:0]    rd_tag,
  output logic [WORD_W-1:0]   rd_word,
  input  logic                wr_word_en,
  input  logic                wr_commit,
  input  logic [IDX_W-1:0]    wr_idx,
  input  logic [CNT_W-1:0]    wr_off,
  input  logic [WORD_W-1:0]   wr_data,
  input  logic [TAG_W-1:0]    wr_tag
);

  typedef struct packed {
    logic                              valid;
    logic [TAG_W-1:0]                  tag;
    logic [BLOCK_WORDS-1:0][WORD_W-1:0] data;
  } line_t;

  line_t lines [SETS];

  // Combinational read of the addressed line and word.
  always_comb begin
    rd_valid = lines[rd_idx].valid;
    rd_tag   = lines[rd_idx].tag;
    rd_word  = lines[rd_idx].data[rd_off];
  end

  // Fill writes; flush_all overrides the valid set of a committing line.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < SETS; i++) lines[i] <= '0;
    end else begin
      if (wr_word_en) lines[wr_idx].data[wr_off] <= wr_data;
      if (wr_commit)  lines[wr_idx].tag <= wr_tag;
      if (flush_all) begin
        for (int i = 0; i < SETS; i++) lines[i].valid <= 1'b0;
      end else if (wr_commit) begin
        lines[wr_idx].valid <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/icache_assoc.sv
// Set-associative, multi-word-block instruction cache with round-robin
// replacement, non-abortable fills and whole-cache flush.
//
// Memory handshake: iREN is the request (held high for the whole fill),
// iwait is the inverse of ready. A word transfers on every rising edge where
// iREN=1 and iwait=0; iaddr only advances on such edges and iload is sampled
// only then. iREN/iaddr come from registered state only.
module icache_assoc
  import cpu_types_pkg::*;
#(
  parameter int SETS        = 8,
  parameter int WAYS        = 2,
  parameter int BLOCK_WORDS = 2
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic               flush,
  input  logic               imemREN,
  input  logic [WORD_W-1:0]  imemaddr,
  output logic               ihit,
  output logic [WORD_W-1:0]  imemload,
  output logic               iREN,
  output logic [WORD_W-1:0]  iaddr,
  input  logic               iwait,
  input  logic [WORD_W-1:0]  iload,
  output logic               state_dbg
);

  localparam int OFF_W = $clog2(BLOCK_WORDS);
  localparam int CNT_W = (OFF_W > 0) ? OFF_W : 1;
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = WORD_W - BYTE_OFF_W - OFF_W - IDX_W;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [WORD_W-1:0] BLK_MASK = WORD_W'(BLOCK_WORDS * 4 - 1);

  icache_state_t state_q, state_d;
  logic [CNT_W-1:0]  counter_q;
  logic [WORD_W-1:0] miss_addr_q;
  logic [WAY_W-1:0]  victim_q, victim;
  logic              flush_pending_q;
  logic [WAY_W-1:0]  ptr_q [SETS];

  logic [IDX_W-1:0]  req_idx, fill_idx;
  logic [TAG_W-1:0]  req_tag, fill_tag;
  logic [CNT_W-1:0]  req_off;
  logic [WAYS-1:0]   way_valid, way_match;
  logic [TAG_W-1:0]  way_tag  [WAYS];
  logic [WORD_W-1:0] way_word [WAYS];
  logic [WORD_W-1:0] hit_word;
  logic              start_fill, flush_all, wr_word, fill_done;

  assign req_idx  = IDX_W'(imemaddr >> (BYTE_OFF_W + OFF_W));
  assign req_tag  = TAG_W'(imemaddr >> (BYTE_OFF_W + OFF_W + IDX_W));
  assign req_off  = CNT_W'((imemaddr >> BYTE_OFF_W) & WORD_W'(BLOCK_WORDS - 1));
  assign fill_idx = IDX_W'(miss_addr_q >> (BYTE_OFF_W + OFF_W));
  assign fill_tag = TAG_W'(miss_addr_q >> (BYTE_OFF_W + OFF_W + IDX_W));

  assign wr_word   = (state_q == ICACHE_FILL) && !iwait;
  assign fill_done = wr_word && (counter_q == CNT_W'(BLOCK_WORDS - 1));
  assign iREN      = (state_q == ICACHE_FILL);
  assign iaddr     = iREN ? (miss_addr_q | (WORD_W'(counter_q) << BYTE_OFF_W)) : '0;
  assign state_dbg = state_q;

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    icache_way #(
      .SETS(SETS), .BLOCK_WORDS(BLOCK_WORDS),
      .TAG_W(TAG_W), .IDX_W(IDX_W), .CNT_W(CNT_W)
    ) u_way (
      .CLK        (CLK),
      .nRST       (nRST),
      .flush_all  (flush_all),
      .rd_idx     (req_idx),
      .rd_off     (req_off),
      .rd_valid   (way_valid[g]),
      .rd_tag     (way_tag[g]),
      .rd_word    (way_word[g]),
      .wr_word_en (wr_word && (victim_q == WAY_W'(g))),
      .wr_commit  (fill_done && (victim_q == WAY_W'(g))),
      .wr_idx     (fill_idx),
      .wr_off     (counter_q),
      .wr_data    (iload),
      .wr_tag     (fill_tag)
    );
  end

  // Parallel tag compare and one-hot OR mux of the matching way's word.
  always_comb begin
    hit_word = '0;
    for (int w = 0; w < WAYS; w++) begin
      way_match[w] = way_valid[w] && (way_tag[w] == req_tag);
      if (way_match[w]) hit_word = hit_word | way_word[w];
    end
  end

  // Victim: lowest invalid way, else the set's round-robin pointer.
  always_comb begin
    victim = ptr_q[req_idx];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!way_valid[w]) victim = WAY_W'(w);
    end
  end

  // Next state, hit outputs and flush decode.
  always_comb begin
    state_d    = state_q;
    ihit       = 1'b0;
    imemload   = '0;
    start_fill = 1'b0;
    flush_all  = 1'b0;
    case (state_q)
      ICACHE_IDLE: begin
        if (flush) begin
          flush_all = 1'b1;
        end else if (imemREN) begin
          if (|way_match) begin
            ihit     = 1'b1;
            imemload = hit_word;
          end else begin
            start_fill = 1'b1;
            state_d    = ICACHE_FILL;
          end
        end
      end
      ICACHE_FILL: begin
        if (fill_done) begin
          state_d   = ICACHE_IDLE;
          flush_all = flush_pending_q || flush;
        end
      end
      default: state_d = ICACHE_IDLE;
    endcase
  end

  // FSM state, miss latch, word counter and deferred flush.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q         <= ICACHE_IDLE;
      counter_q       <= '0;
      miss_addr_q     <= '0;
      victim_q        <= '0;
      flush_pending_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_fill) begin
        miss_addr_q <= imemaddr & ~BLK_MASK;
        victim_q    <= victim;
        counter_q   <= '0;
      end else if (wr_word) begin
        counter_q <= fill_done ? '0 : counter_q + CNT_W'(1);
      end
      if (fill_done)                          flush_pending_q <= 1'b0;
      else if (state_q == ICACHE_FILL && flush) flush_pending_q <= 1'b1;
    end
  end

  // Round-robin pointer advances when a fill completes in that set.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int s = 0; s < SETS; s++) ptr_q[s] <= '0;
    end else if (fill_done) begin
      ptr_q[fill_idx] <= (ptr_q[fill_idx] == WAY_W'(WAYS - 1)) ? '0
                                                              : ptr_q[fill_idx] + WAY_W'(1);
    end
  end

endmodule
